mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Shares one single-port memory between the core's instruction-fetch and data load/store requesters. Sits between the processor core and the memory model, replacing separate fetch/read/write memory ports with one sequenced port. Only one transaction is outstanding at a time. Data requests have priority, with a starvation guard for fetch.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata/mem_err; must be >=1 (elaboration error if 0)
STARVE_LIMIT, 4, consecutive data grants with fetch pending before fetch is forced to win; must be >=1

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-high reset
fetch_req_valid  in  1  fetch request
fetch_req_ready  out  1  fetch accepted this cycle when valid&ready
fetch_req_addr  in  ADDR_W  fetch address
fetch_resp_valid  out  1  one-cycle fetch response pulse
fetch_resp_data  out  DATA_W  instruction word
fetch_resp_err  out  1  memory error on fetch
data_req_valid  in  1  load/store request
data_req_ready  out  1  data accepted when valid&ready
data_req_we  in  1  1=store, 0=load
data_req_addr  in  ADDR_W  load/store address
data_req_wdata  in  DATA_W  store data
data_resp_valid  out  1  one-cycle data response pulse (loads and stores)
data_resp_data  out  DATA_W  load data; 0 for stores
data_resp_err  out  1  memory error on load/store
mem_en  out  1  memory command strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
mem_err  in  1  memory error, valid with mem_rdata
busy  out  1  state != IDLE

Behaviour:
- Reset (async, active-high): state IDLE, all outputs 0, latched command 0, starvation counter 0. Reset mid-transaction aborts it; no response is issued for the aborted request.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: the ready of the arbitration winner is driven combinationally (=valid of the winner). The loser's ready is 0. On accept, latch owner/we/addr/wdata and go to ISSUE.
- ISSUE (1 cycle): mem_en=1, mem_we/addr/wdata from the latch. Load latency counter with MEM_LATENCY-1 and go to WAIT.
- WAIT: decrement each cycle. When the counter is 0, sample mem_rdata/mem_err into the response registers and go to RESP. For MEM_LATENCY=1, WAIT lasts 1 cycle.
- RESP (1 cycle): the owner's resp_valid=1 with registered data/err. For stores, data=0 and err=sampled mem_err. Return to IDLE.
- Latency: accept at cycle T gives mem_en at T+1 and resp_valid at T+2+MEM_LATENCY. Throughput is one transaction per MEM_LATENCY+3 cycles. Ready is 0 outside IDLE.
- mem_en, mem_we, mem_addr and mem_wdata are 0 outside ISSUE.
- Arbitration when both are valid in IDLE: data wins unless starve_cnt==STARVE_LIMIT, in which case fetch wins.
- starve_cnt:
  - Increments on a data grant while fetch_req_valid=1, saturating at STARVE_LIMIT.
  - Clears on a fetch grant.
  - Clears in any IDLE cycle with fetch_req_valid=0.
- A requester must hold valid and its payload stable until accepted (protocol rule; checked by bench assertions, not by RTL).
- Responses cannot be back-pressured.
- mem_err is passed through unchanged; the arbiter does not retry.

Optional Feature:
MEM_ARB_STATS_EN.
- Defined: adds 32-bit outputs stat_fetch_grants, stat_data_grants and stat_conflict_cycles.
  - Conflict cycles are IDLE cycles with both valids high.
  - All three wrap at 2^32 and reset to 0.
- Undefined: these ports are absent and no counter logic is built.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE/ISSUE/WAIT/RESP), owner enum (OWN_FETCH/OWN_DATA), packed mem_cmd_t {we, addr, wdata}.
- Sub-module mem_arb_priority: starvation counter plus winner select. Inputs are both valids, idle, and accept. Outputs are grant_fetch and grant_data.

Test Plan:
- Single fetch, addr 0x100, mem returns 0x00000013, MEM_LATENCY=1, accept at T -> mem_en at T+1, fetch_resp_valid at T+3, data 0x13, err 0.
- Store addr 0x200, wdata 0xDEADBEEF, then load 0x200 -> mem_we=1 only in the store's ISSUE cycle; load response 0xDEADBEEF; store response data 0.
- Both valid continuously, STARVE_LIMIT=4 -> grant sequence D,D,D,D,F,D,D,D,D,F; stat counters (if enabled) 8 data, 2 fetch.
- mem_err=1 on a load, MEM_LATENCY=3 -> data_resp_valid at T+5 with err=1; next request still accepted.
- RESET asserted during WAIT -> all outputs 0 asynchronously; no resp_valid after release; the next fetch completes normally.
- fetch valid while data is in flight -> fetch_req_ready stays 0 until IDLE, then asserts the same cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, transaction owner
// and the latched memory command.
package mem_arb_pkg;

  localparam int CMD_ADDR_W = 32;
  localparam int CMD_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH,
    OWN_DATA
  } arb_owner_t;

  typedef struct packed {
    logic                  we;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arb_priority.sv
// Fetch/data winner select: data has priority unless fetch has been passed
// over STARVE_LIMIT consecutive times while pending.
module mem_arb_priority
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic fetch_valid,
  input  logic data_valid,
  input  logic idle,
  input  logic accept,
  output logic grant_fetch,
  output logic grant_data
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

  always_comb begin
    grant_fetch = idle & fetch_valid & (~data_valid | starved);
    grant_data  = idle & data_valid & ~grant_fetch;
  end

  // Counter only moves on grants or on an IDLE cycle with no fetch pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (accept && grant_fetch) begin
      starve_cnt <= '0;
    end else if (accept && grant_data && fetch_valid) begin
      if (!starved) starve_cnt <= starve_cnt + 1'b1;
    end else if (idle && !fetch_valid) begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory sequencer shared by instruction fetch and load/store.
// Optional `MEM_ARB_STATS_EN adds grant and conflict statistics counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              fetch_req_valid,
  output logic              fetch_req_ready,
  input  logic [ADDR_W-1:0] fetch_req_addr,
  output logic              fetch_resp_valid,
  output logic [DATA_W-1:0] fetch_resp_data,
  output logic              fetch_resp_err,
  input  logic              data_req_valid,
  output logic              data_req_ready,
  input  logic              data_req_we,
  input  logic [ADDR_W-1:0] data_req_addr,
  input  logic [DATA_W-1:0] data_req_wdata,
  output logic              data_resp_valid,
  output logic [DATA_W-1:0] data_resp_data,
  output logic              data_resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err,
  output logic              busy
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_fetch_grants,
  output logic [31:0]       stat_data_grants,
  output logic [31:0]       stat_conflict_cycles
`endif
);

  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("mem_port_arbiter: MEM_LATENCY must be >= 1");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_starve
    $error("mem_port_arbiter: STARVE_LIMIT must be >= 1");
  end
  if (ADDR_W != CMD_ADDR_W || DATA_W != CMD_DATA_W) begin : g_bad_width
    $error("mem_port_arbiter: ADDR_W/DATA_W must match mem_arb_pkg command widths");
  end

  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  arb_state_t       state, state_next;
  arb_owner_t       owner;
  mem_cmd_t         cmd;
  logic [LAT_W-1:0] lat_cnt;
  logic [DATA_W-1:0] resp_data;
  logic             resp_err;
  logic             idle, accept, grant_fetch, grant_data;

  assign idle   = (state == IDLE);
  assign accept = grant_fetch | grant_data;

  mem_arb_priority #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_priority (
    .clk        (CLK),
    .rst        (RESET),
    .fetch_valid(fetch_req_valid),
    .data_valid (data_req_valid),
    .idle       (idle),
    .accept     (accept),
    .grant_fetch(grant_fetch),
    .grant_data (grant_data)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (lat_cnt == '0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      owner     <= OWN_FETCH;
      cmd       <= '0;
      lat_cnt   <= '0;
      resp_data <= '0;
      resp_err  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          owner     <= grant_data ? OWN_DATA : OWN_FETCH;
          cmd.we    <= grant_data & data_req_we;
          cmd.addr  <= grant_data ? data_req_addr : fetch_req_addr;
          cmd.wdata <= grant_data ? data_req_wdata : '0;
        end
        ISSUE: lat_cnt <= LAT_W'(MEM_LATENCY - 1);
        WAIT: begin
          if (lat_cnt == '0) begin
            resp_data <= cmd.we ? '0 : mem_rdata;
            resp_err  <= mem_err;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    fetch_req_ready  = grant_fetch;
    data_req_ready   = grant_data;
    busy             = ~idle;
    mem_en           = (state == ISSUE);
    mem_we           = mem_en & cmd.we;
    mem_addr         = mem_en ? cmd.addr : '0;
    mem_wdata        = mem_en ? cmd.wdata : '0;
    fetch_resp_valid = (state == RESP) && (owner == OWN_FETCH);
    data_resp_valid  = (state == RESP) && (owner == OWN_DATA);
    fetch_resp_data  = fetch_resp_valid ? resp_data : '0;
    fetch_resp_err   = fetch_resp_valid & resp_err;
    data_resp_data   = data_resp_valid ? resp_data : '0;
    data_resp_err    = data_resp_valid & resp_err;
  end

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stat_fetch_grants    <= '0;
      stat_data_grants     <= '0;
      stat_conflict_cycles <= '0;
    end else begin
      if (grant_fetch) stat_fetch_grants <= stat_fetch_grants + 32'd1;
      if (grant_data)  stat_data_grants  <= stat_data_grants + 32'd1;
      if (idle && fetch_req_valid && data_req_valid)
        stat_conflict_cycles <= stat_conflict_cycles + 32'd1;
    end
  end
`endif

endmodule
